// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MUL/MULHU/DIVU/REMU sequencer that borrows the shared ripple ALU.
// Shift-add multiply and restoring divide, one ALU add/subtract per cycle.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_ainvert,
  output logic             alu_binvert,
  output logic             alu_cin,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout
);

  localparam int CNTW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t            state;
  logic [1:0]        op;
  logic [CNTW-1:0]   cnt;
  // acc holds hi (multiply) or R (divide); shreg holds lo or Q; opb holds mc or D
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  shreg;
  logic [WIDTH-1:0]  opb;
  logic [WIDTH-1:0]  div_s;
  logic              div_ge;

  assign div_s  = {acc[WIDTH-2:0], shreg[WIDTH-1]};
  assign div_ge = acc[WIDTH-1] | alu_cout;

  // The ALU is only claimed in CALC; otherwise it is left idle for the EX mux.
  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_ainvert = 1'b0;
    alu_binvert = 1'b0;
    alu_cin     = 1'b0;
    alu_op      = 2'b00;
    if (state == CALC) begin
      alu_op = 2'b10;
      if (op[1]) begin
        alu_a       = div_s;
        alu_b       = opb;
        alu_binvert = 1'b1;
        alu_cin     = 1'b1;
      end else begin
        alu_a = acc;
        alu_b = shreg[0] ? opb : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      busy        <= 1'b0;
      resp_result <= '0;
      cnt         <= '0;
      op          <= 2'b00;
      acc         <= '0;
      shreg       <= '0;
      opb         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op        <= req_op;
            acc       <= '0;
            shreg     <= req_a;
            opb       <= req_b;
            cnt       <= '0;
            state     <= CALC;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        CALC: begin
          if (op[1]) begin
            acc   <= div_ge ? alu_result : div_s;
            shreg <= {shreg[WIDTH-2:0], div_ge};
          end else begin
            {acc, shreg} <= {alu_cout, alu_result, shreg[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNTW'(WIDTH - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          // First DONE cycle captures the result; the handshake is only honoured once it is visible.
          if (!resp_valid) begin
            resp_valid  <= 1'b1;
            resp_result <= op[0] ? acc : shreg;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
